// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the round-robin UART transmit scheduler.
//   - state_e       : frame FSM state encoding (IDLE/START/DATA/STOP)
//   - TICKS_PER_BIT : 16x oversampling ticks per serial bit
//   - DATA_BITS     : payload bits per 8N1 frame
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS     = 8;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin priority encoder.
// Ports:
//   req  [NREQ-1:0] : request vector
//   ptr  [GW-1:0]   : highest-priority index; search goes upward and wraps
//   pick [GW-1:0]   : index of the first asserted request at or after ptr
//   any             : at least one request asserted
module rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   pick,
  output logic            any
);

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    any  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[GW'(idx)]) begin
        any  = 1'b1;
        pick = GW'(idx);
      end else begin
        pick = pick;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler sharing one 8N1 UART line among NREQ
// byte producers. Bit timing comes from an external 16x baud tick.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   baud16              : one-cycle 16x-baud tick
//   req_valid/req_data  : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready           : one-hot accept, combinational, IDLE only
//   tx                  : serial line, idle high
//   busy                : frame in progress
//   grant_id            : requester owning the current/last frame
//   frame_done          : one-cycle pulse when the stop bit completes
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud16,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx,
  output logic              busy,
  output logic [GW-1:0]     grant_id,
  output logic              frame_done
);

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic [GW-1:0]   pick;
  logic            any_req;
  logic            tick_last;

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_rr_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .any  (any_req)
  );

  // Last oversampling tick of the current bit period.
  assign tick_last = baud16 && (tick_cnt_q == 4'(TICKS_PER_BIT - 1));

  // Accept strobe: only in IDLE, never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && any_req && !reset) begin
      req_ready[pick] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state, datapath and registered-output precomputation.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // baud16 is ignored here, so a tick on the handshake edge is not counted.
        if (any_req) begin
          shreg_d    = req_data[int'(pick)*8 +: 8];
          grant_id_d = pick;
          if (int'(pick) == NREQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = pick + GW'(1);
          end
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // The 4-bit counter wraps to 0 on the 16th tick.
        if (baud16) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
        if (tick_last) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (baud16) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
        if (tick_last) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud16) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
        if (tick_last) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they are registered
    // and line up with the state they describe.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= 8'd0;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: frame-level behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        baud16 = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int bc = 0;
  int tick_div = 4;
  bit tick_en = 1'b0;
  bit chk_en = 1'b0;
  bit reload_en = 1'b0;
  int gids [8];
  int ng = 0;
  bit txlog [4096];

  // frame-level model state
  int   m_busy = 0;
  int   m_ticks = 0;
  int   m_ptr = 0;
  int   m_id = 0;
  int   m_fd = 0;
  logic [7:0] m_data = 8'h00;
  int   m_hs = 0;
  int   m_hs_id = 0;
  int   m_p = 0;

  uart_tx_sched #(.NREQ(4), .GW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud16     (baud16),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int m_pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Model: a frame is 160 counted ticks after the accept edge.
  always @(posedge clk) begin
    m_hs = 0;
    if (reset) begin
      m_busy = 0; m_ticks = 0; m_ptr = 0; m_id = 0; m_fd = 0;
    end else if (m_busy == 0) begin
      m_fd = 0;
      m_p = m_pick(req_valid, m_ptr);
      if (m_p >= 0) begin
        m_busy = 1; m_ticks = 0; m_id = m_p; m_ptr = (m_p + 1) % 4;
        m_data = req_data[8*m_p +: 8];
        m_hs = 1; m_hs_id = m_p;
      end
    end else begin
      m_fd = 0;
      if (baud16) begin
        m_ticks++;
        if (m_ticks == 160) begin
          m_busy = 0; m_fd = 1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : cmp
    int pc;
    int bi;
    logic [31:0] e_rdy;
    logic e_tx;
    if (chk_en) begin
      pc = m_pick(req_valid, m_ptr);
      e_rdy = (m_busy == 0 && !reset && pc >= 0) ? (32'd1 << pc) : 32'd0;
      bi = m_ticks / 16;
      if (m_busy == 0)   e_tx = 1'b1;
      else if (bi == 0)  e_tx = 1'b0;
      else if (bi <= 8)  e_tx = m_data[bi-1];
      else               e_tx = 1'b1;
      check("tx", 32'(tx), 32'(e_tx));
      check("busy", 32'(busy), 32'(m_busy));
      check("grant_id", 32'(grant_id), 32'(m_id));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("req_ready", 32'(req_ready), e_rdy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (m_hs != 0) req_valid[m_hs_id] = 1'b0;
    bc++;
    baud16 = tick_en && (bc % tick_div == 0);
  endtask

  task automatic reset_dut();
    tick_en = 1'b0; baud16 = 1'b0; req_valid = 4'b0000; reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // Run until nf frame_done pulses; cyc counts edges, the first step included.
  task automatic run_frames(input int nf, input int limit, output int cyc);
    int nfd;
    int hs_now;
    nfd = 0; ng = 0; cyc = 0;
    while (nfd < nf && cyc < limit) begin
      step();
      cyc++;
      hs_now = m_hs;
      if (m_hs != 0 && reload_en && m_hs_id == 0) begin
        reload_en = 1'b0;
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'h20;
      end
      @(negedge clk);
      if (cyc < 4096) txlog[cyc] = tx;
      if (hs_now != 0 && ng < 8) begin
        gids[ng] = int'(grant_id);
        ng++;
      end
      if (frame_done) nfd++;
    end
    check("frames_seen", 32'(nfd), 32'(nf));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int first_hi;
    int nz;
    int rr;
    logic [9:0] exp_bits;

    // Reset state
    reset_dut();
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    chk_en = 1'b1;
    step();

    // Single frame 0xA5 from requester 2, tick every 4 clk
    tick_div = 4; tick_en = 1'b1; bc = 0; baud16 = 1'b0;
    req_data[23:16] = 8'hA5; req_valid = 4'b0100;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h4);
    run_frames(1, 2000, cyc);
    check("t1_grant", 32'(gids[0]), 32'd2);
    check("t1_fd_latency", 32'(cyc - 1), 32'd640);
    exp_bits = 10'b11_0100_1010;  // stop,d7..d0,start (LSB first on the line)
    for (int b = 0; b < 10; b++) begin
      check("t1_txbit", 32'(txlog[64*b + 33]), 32'(exp_bits[b]));
    end

    // Contention: all four valid, requester 0 re-offers after its grant
    reset_dut();
    tick_div = 4; tick_en = 1'b1; bc = 0; baud16 = 1'b0;
    req_data = 32'h13121110; req_valid = 4'b1111; reload_en = 1'b1;
    run_frames(5, 4000, cyc);
    check("t2_g0", 32'(gids[0]), 32'd0);
    check("t2_g1", 32'(gids[1]), 32'd1);
    check("t2_g2", 32'(gids[2]), 32'd2);
    check("t2_g3", 32'(gids[3]), 32'd3);
    check("t2_g4", 32'(gids[4]), 32'd0);
    check("t2_back_to_back_len", 32'(cyc - 1), 32'd3200);

    // Fairness: serve requester 1 so the pointer sits at 2, then 1 and 3 compete
    reset_dut();
    tick_div = 1; tick_en = 1'b1;
    req_data[15:8] = 8'h41; req_valid = 4'b0010;
    run_frames(1, 400, cyc);
    check("t3_first", 32'(gids[0]), 32'd1);
    step();
    req_data[15:8] = 8'h51; req_data[31:24] = 8'h31; req_valid = 4'b1010;
    run_frames(2, 800, cyc);
    check("t3_g0", 32'(gids[0]), 32'd3);
    check("t3_g1", 32'(gids[1]), 32'd1);

    // baud16 high on the handshake edge is not counted
    reset_dut();
    tick_div = 4; tick_en = 1'b1; bc = 0; baud16 = 1'b1;
    req_data[7:0] = 8'hFF; req_valid = 4'b0001;
    run_frames(1, 2000, cyc);
    first_hi = -1;
    for (int k = 2; k < 4096; k++) begin
      if (first_hi < 0 && k <= cyc && txlog[k]) first_hi = k;
    end
    check("t4_start_len", 32'(first_hi - 1), 32'd64);

    // Reset in the middle of data bit 3
    reset_dut();
    tick_div = 1; tick_en = 1'b1;
    req_data[23:16] = 8'h3C; req_valid = 4'b0100;
    for (int i = 0; i < 70; i++) step();
    reset = 1'b1; req_data[7:0] = 8'h5A; req_valid = 4'b0001;
    @(negedge clk);
    check("t5_ready_in_reset", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_grant", 32'(grant_id), 32'd0);
    check("t5_fd", 32'(frame_done), 32'd0);
    run_frames(1, 400, cyc);
    check("t5_grant_after", 32'(gids[0]), 32'd0);
    check("t5_frame_len", 32'(cyc - 1), 32'd160);

    // No ticks for 1000 clk after a handshake
    reset_dut();
    tick_en = 1'b0; baud16 = 1'b0;
    req_data[15:8] = 8'h77; req_valid = 4'b0010;
    step();
    req_data[31:24] = 8'h99; req_valid[3] = 1'b1;
    nz = 0; rr = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      @(negedge clk);
      if (tx !== 1'b0) nz++;
      if (req_ready !== 4'b0000) rr++;
    end
    check("t6_tx_low", 32'(nz), 32'd0);
    check("t6_no_ready", 32'(rr), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    tick_div = 1; tick_en = 1'b1;
    run_frames(2, 1000, cyc);
    check("t6_next_grant", 32'(gids[0]), 32'd3);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
